// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing, framebuffer geometry, colour type and colour-bar palette
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_TOTAL = 525;
  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int BAR_W = 80;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;
  localparam logic [11:0] BAR_RGB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
  function automatic rgb12_t barColour(input logic [9:0] x);
    return rgb12_t'(BAR_RGB[3'(x / 10'(BAR_W))]);
  endfunction
endpackage

// File: rtl/fb_ram.sv
// fb_ram: single-port framebuffer with a one-cycle registered read; the array is never reset
module fb_ram #(
  parameter int DEPTH = vga_pkg::FB_DEPTH,
  parameter int AW = 15,
  parameter int DW = 12
) (
  input  logic          pixelClk,
  input  logic          wrEn,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wrData,
  output logic [DW-1:0] rdData
);
  logic [DW-1:0] mem [DEPTH];
  // read-first single port so the array maps onto block RAM
  always_ff @(posedge pixelClk) begin
    if (wrEn) mem[addr] <= wrData;
    rdData <= mem[addr];
  end
endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 4x-upscaled framebuffer scanout with aligned syncs and a blanking-only write port
module vga_fb_scanout #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int SCALE_LOG2 = 2
) (
  input  logic        pixelClk,
  input  logic        locked,
  input  logic [9:0]  xCor,
  input  logic [9:0]  yCor,
  input  logic        hVis,
  input  logic        vVis,
  input  logic        hClk,
  input  logic        vClk,
  input  logic        wrValid,
  output logic        wrReady,
  input  logic [14:0] wrAddr,
  input  logic [11:0] wrData,
  input  logic        patternSel,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frameStart,
  output logic [15:0] frameCount
);
  import vga_pkg::*;
  localparam int DEPTH = FB_W * FB_H;
  logic [14:0] rdAddr, ramAddr;
  logic wrEn, origin, patLatch;
  logic visA, hA, vA, startA, visB, hB, vB, startB;
  rgb12_t ramData, barA, barB, dataB, pix;
  // the read address comes from the live coordinates so the write gate and the read share one cycle
  assign origin = (xCor == '0) && (yCor == '0);
  assign rdAddr = 15'((yCor >> SCALE_LOG2) * FB_W) + 15'(xCor >> SCALE_LOG2);
  assign wrReady = locked & ~(hVis & vVis);
  assign wrEn = wrValid & wrReady & (int'(wrAddr) < DEPTH);
  assign ramAddr = wrEn ? wrAddr : rdAddr;
  assign pix = visB ? (patLatch ? barB : dataB) : '0;
  fb_ram #(.DEPTH(DEPTH)) uRam (
    .pixelClk(pixelClk),
    .wrEn(wrEn),
    .addr(ramAddr),
    .wrData(wrData),
    .rdData(ramData)
  );
  // first stage: capture sideband and bar colour alongside the RAM read; latch pattern mode at (0,0)
  always_ff @(posedge pixelClk or negedge locked) begin
    if (!locked) begin
      visA <= 1'b0;
      hA <= 1'b1;
      vA <= 1'b1;
      startA <= 1'b0;
      barA <= '0;
      patLatch <= 1'b0;
    end else begin
      visA <= hVis & vVis;
      hA <= hClk;
      vA <= vClk;
      startA <= origin;
      barA <= barColour(xCor);
      if (origin) patLatch <= patternSel;
    end
  end
  // second stage: register RAM data with the sideband delayed to match
  always_ff @(posedge pixelClk or negedge locked) begin
    if (!locked) begin
      visB <= 1'b0;
      hB <= 1'b1;
      vB <= 1'b1;
      startB <= 1'b0;
      barB <= '0;
      dataB <= '0;
    end else begin
      visB <= visA;
      hB <= hA;
      vB <= vA;
      startB <= startA;
      barB <= barA;
      dataB <= ramData;
    end
  end
  // output stage: blank outside the picture, count frames on the (0,0) pulse
  always_ff @(posedge pixelClk or negedge locked) begin
    if (!locked) begin
      hSync <= 1'b1;
      vSync <= 1'b1;
      red <= '0;
      green <= '0;
      blue <= '0;
      frameStart <= 1'b0;
      frameCount <= '0;
    end else begin
      hSync <= hB;
      vSync <= vB;
      red <= pix.r;
      green <= pix.g;
      blue <= pix.b;
      frameStart <= startB;
      frameCount <= frameCount + 16'(startB);
    end
  end
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: directed scan frames compared every cycle against a behavioural pixel model
module tb_vga_fb_scanout;
  import vga_pkg::*;
  logic pixelClk = 1'b0, locked = 1'b0;
  logic [9:0] xCor = 10'd799, yCor = 10'd524;
  logic hVis = 1'b0, vVis = 1'b0, hClk = 1'b1, vClk = 1'b1, wrValid = 1'b0, patternSel = 1'b0;
  logic [14:0] wrAddr = '0;
  logic [11:0] wrData = '0;
  logic wrReady, hSync, vSync, frameStart;
  logic [3:0] red, green, blue;
  logic [15:0] frameCount;
  int vectors = 0, miscompares = 0;

  typedef struct { logic hs, vs, fs; logic [11:0] rgb; int x, y; } exp_t;
  typedef struct { int ph, x, y; logic [11:0] c; } pin_t;

  logic [11:0] mem [FB_DEPTH];
  logic [26:0] wq [$];
  exp_t expQ [$];
  exp_t cur, e;
  pin_t pins [$];
  logic [15:0] expCount = '0;
  logic expPat = 1'b0, presentQ = 1'b0, decoyOn = 1'b0;
  int phase = 0, h0Low = 0, fs4 = 0;
  int rows [8] = '{0, 3, 4, 240, 476, 479, 490, 524};

  vga_fb_scanout dut (
    .pixelClk(pixelClk), .locked(locked), .xCor(xCor), .yCor(yCor),
    .hVis(hVis), .vVis(vVis), .hClk(hClk), .vClk(vClk),
    .wrValid(wrValid), .wrReady(wrReady), .wrAddr(wrAddr), .wrData(wrData),
    .patternSel(patternSel), .hSync(hSync), .vSync(vSync),
    .red(red), .green(green), .blue(blue),
    .frameStart(frameStart), .frameCount(frameCount)
  );

  always #20 pixelClk = ~pixelClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t idle();
    exp_t r;
    r.hs = 1'b1; r.vs = 1'b1; r.fs = 1'b0; r.rgb = 12'h000; r.x = -1; r.y = -1;
    return r;
  endfunction

  function automatic logic [11:0] bar(input int x);
    case (x / 80)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic void addPin(input int ph, input int x, input int y, input logic [11:0] c);
    pin_t p;
    p.ph = ph; p.x = x; p.y = y; p.c = c;
    pins.push_back(p);
  endfunction

  // model: each sampled input pixel becomes one expected output three cycles later
  always @(posedge pixelClk or negedge locked) begin
    if (!locked) begin
      expQ = {};
      expQ.push_back(idle());
      expQ.push_back(idle());
      cur = idle();
      expCount = '0;
      expPat = 1'b0;
    end else begin
      if (xCor == 0 && yCor == 0) expPat = patternSel;
      e.hs = hClk; e.vs = vClk; e.fs = (xCor == 0 && yCor == 0);
      e.x = int'(xCor); e.y = int'(yCor);
      e.rgb = !(hVis && vVis) ? 12'h000 : expPat ? bar(e.x) : mem[(e.y / 4) * 160 + e.x / 4];
      if (wrValid && !(hVis && vVis)) begin
        if (int'(wrAddr) < FB_DEPTH) mem[wrAddr] = wrData;
        if (presentQ) void'(wq.pop_front());
      end
      expQ.push_back(e);
      cur = expQ.pop_front();
      if (cur.fs) expCount++;
    end
  end

  // compare every cycle on the falling edge, plus literal pins on selected output pixels
  always @(negedge pixelClk) begin
    check("out", {hSync, vSync, red, green, blue, frameStart, frameCount, wrReady},
          {cur.hs, cur.vs, cur.rgb, cur.fs, expCount, locked & ~(hVis & vVis)});
    if (phase == 1 && cur.y == 0 && !hSync) h0Low++;
    if (phase == 4 && frameStart) fs4++;
    foreach (pins[i])
      if (pins[i].ph == phase && pins[i].x == cur.x && pins[i].y == cur.y)
        check($sformatf("pin%0d(%0d,%0d)", phase, cur.x, cur.y), {20'd0, red, green, blue}, {20'd0, pins[i].c});
  end

  task automatic step(input int x, input int y);
    xCor = 10'(x); yCor = 10'(y);
    hVis = x < H_VISIBLE; vVis = y < V_VISIBLE;
    hClk = !(x >= 656 && x < 752); vClk = !(y >= 490 && y < 492);
    if (decoyOn) begin
      wrValid = 1'b1; wrAddr = 15'(x / 4); wrData = 12'hABC; presentQ = 1'b0;
    end else if (wq.size() > 0) begin
      wrValid = 1'b1; {wrAddr, wrData} = wq[0]; presentQ = 1'b1;
    end else begin
      wrValid = 1'b0; presentQ = 1'b0;
    end
    @(posedge pixelClk);
    #1;
  endtask

  task automatic frame(input int decoyRow, input int patRow, input logic patVal);
    foreach (rows[r])
      for (int x = 0; x < H_TOTAL; x++) begin
        if (rows[r] == patRow && x == 0) patternSel = patVal;
        decoyOn = (rows[r] == decoyRow) && x < H_VISIBLE;
        step(x, rows[r]);
      end
    decoyOn = 1'b0;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    addPin(2, 0, 0, 12'h000); addPin(2, 3, 3, 12'hF00); addPin(2, 4, 3, 12'h000);
    addPin(2, 636, 476, 12'h0F0); addPin(2, 639, 479, 12'h0F0); addPin(2, 635, 479, 12'h000);
    addPin(3, 0, 0, 12'hF00); addPin(3, 3, 0, 12'hF00); addPin(3, 4, 0, 12'h000); addPin(3, 639, 479, 12'h0F0);
    addPin(4, 0, 0, 12'hFFF); addPin(4, 79, 3, 12'hFFF); addPin(4, 80, 3, 12'hFF0); addPin(4, 160, 240, 12'h0FF);
    addPin(4, 240, 0, 12'h0F0); addPin(4, 320, 0, 12'hF0F); addPin(4, 400, 0, 12'hF00); addPin(4, 480, 0, 12'h00F);
    addPin(4, 560, 0, 12'h000); addPin(4, 639, 479, 12'h000);
    addPin(5, 0, 0, 12'hF00);
    addPin(6, 0, 0, 12'hF00); addPin(6, 3, 3, 12'hF00); addPin(6, 60, 4, 12'h000); addPin(6, 639, 479, 12'h0F0);
    repeat (3) step(780, 500);
    check("rstInit", {hSync, vSync, red, green, blue, frameStart, frameCount, wrReady}, 32'hC000_0000);
    locked = 1'b1;
    foreach (rows[r])
      if (rows[r] < V_VISIBLE)
        for (int c = 0; c < 160; c++) wq.push_back({15'((rows[r] / 4) * 160 + c), 12'h000});
    for (int i = 0; i < 3000 && wq.size() > 0; i++) step(780, 500);
    phase = 1;
    frame(-1, -1, 1'b0);
    check("hSyncLowRow0", 32'(h0Low), 32'd96);
    check("frameCount1", {16'd0, frameCount}, 32'd1);
    wq.push_back({15'd0, 12'hF00});
    wq.push_back({15'd19199, 12'h0F0});
    wq.push_back({15'd20000, 12'hABC});
    phase = 2;
    frame(4, -1, 1'b0);
    check("frameCount2", {16'd0, frameCount}, 32'd2);
    phase = 3;
    frame(-1, 240, 1'b1);
    phase = 4;
    frame(-1, -1, 1'b0);
    check("frameCount4", {16'd0, frameCount}, 32'd4);
    check("frameStart4", 32'(fs4), 32'd1);
    phase = 5;
    for (int x = 0; x < 700; x++) begin
      if (x == 0) patternSel = 1'b0;
      step(x, 0);
    end
    decoyOn = 1'b1;
    locked = 1'b0;
    #1;
    check("rstAsync", {hSync, vSync, red, green, blue, frameStart, frameCount, wrReady}, 32'hC000_0000);
    for (int x = 700; x < 705; x++) step(x, 0);
    decoyOn = 1'b0;
    locked = 1'b1;
    step(0, 3);
    step(1, 3);
    check("release2", {20'd0, red, green, blue}, 32'h000);
    step(2, 3);
    check("release3", {20'd0, red, green, blue}, 32'hF00);
    for (int x = 3; x < H_TOTAL; x++) step(x, 3);
    phase = 6;
    frame(-1, -1, 1'b0);
    check("frameCount6", {16'd0, frameCount}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
